// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// AXI4-Lite response/protection encodings and the canonical NOP word.
package fetcher_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_DATA = 2'd2
  } fetch_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0]  AXI_PROT_INSTR = 3'b100;
  localparam logic [31:0] RV_NOP         = 32'h00000013;

  // Word address containing a byte address (low two bits cleared).
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetcher.sv
// Instruction fetch unit: reads one 32-bit word at pc over an AXI4-Lite read
// channel when enabled, then presents it to the decoder with a completed pulse.
// Optional feature macro: FETCHER_ALIGN_CHECK_EN (misaligned-pc fault, no bus access).
module fetcher
  import fetcher_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  output logic        completed,
  input  logic [31:0] pc,
  output logic [31:0] instr_raw,
  output logic [31:0] pc_out,
  output logic        fetch_fault,
  output logic        misaligned,
  output logic [31:0] mem_araddr,
  output logic [2:0]  mem_arprot,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready
);

  fetch_state_t state_q, state_d;
  logic         completed_q, completed_d;
  logic         arvalid_q, arvalid_d;
  logic         rready_q, rready_d;
  logic         fault_q, fault_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;
`ifdef FETCHER_ALIGN_CHECK_EN
  logic         misaligned_q, misaligned_d;
`endif

  // Next-state logic: request address, wait for data, then publish the word.
  always_comb begin
    state_d     = state_q;
    completed_d = 1'b0;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    fault_d     = fault_q;
    araddr_d    = araddr_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
`ifdef FETCHER_ALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    unique case (state_q)
      FETCH_IDLE: begin
        if (enabled) begin
`ifdef FETCHER_ALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) begin
            completed_d  = 1'b1;
            misaligned_d = 1'b1;
            fault_d      = 1'b0;
            instr_d      = NOP_INSTR;
            pc_out_d     = pc;
          end else begin
            misaligned_d = 1'b0;
            fault_d      = 1'b0;
            pc_out_d     = pc;
            araddr_d     = word_align(pc);
            arvalid_d    = 1'b1;
            state_d      = FETCH_ADDR;
          end
`else
          fault_d   = 1'b0;
          pc_out_d  = pc;
          araddr_d  = word_align(pc);
          arvalid_d = 1'b1;
          state_d   = FETCH_ADDR;
`endif
        end
      end
      FETCH_ADDR: begin
        if (mem_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = FETCH_DATA;
        end
      end
      FETCH_DATA: begin
        if (mem_rvalid) begin
          rready_d    = 1'b0;
          completed_d = 1'b1;
          state_d     = FETCH_IDLE;
          if (mem_rresp == AXI_RESP_OKAY) begin
            instr_d = mem_rdata;
          end else begin
            instr_d = NOP_INSTR;
            fault_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= FETCH_IDLE;
      completed_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      fault_q     <= 1'b0;
      araddr_q    <= 32'h0;
      pc_out_q    <= 32'h0;
      instr_q     <= NOP_INSTR;
`ifdef FETCHER_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      completed_q <= completed_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      fault_q     <= fault_d;
      araddr_q    <= araddr_d;
      pc_out_q    <= pc_out_d;
      instr_q     <= instr_d;
`ifdef FETCHER_ALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign completed   = completed_q;
  assign instr_raw   = instr_q;
  assign pc_out      = pc_out_q;
  assign fetch_fault = fault_q;
  assign mem_araddr  = araddr_q;
  assign mem_arprot  = AXI_PROT_INSTR;
  assign mem_arvalid = arvalid_q;
  assign mem_rready  = rready_q;
`ifdef FETCHER_ALIGN_CHECK_EN
  assign misaligned  = misaligned_q;
`else
  assign misaligned  = 1'b0;
`endif

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed vector table, multi-cycle corner
// sequences and randomized fetches against a transaction-level reference model.
module tb_fetcher;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  logic        completed;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic [31:0] pc_out;
  logic        fetch_fault;
  logic        misaligned;
  logic [31:0] mem_araddr;
  logic [2:0]  mem_arprot;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;

  int vectors = 0;
  int miscompares = 0;

  // Slave configuration, written by the main sequence between transactions.
  int          ar_delay = 0;
  int          r_delay = 0;
  logic [1:0]  resp_val = 2'b00;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  logic        spurious = 1'b0;
  logic        rst_at_edge = 1'b1;

  fetcher dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .completed(completed), .pc(pc),
    .instr_raw(instr_raw), .pc_out(pc_out), .fetch_fault(fetch_fault),
    .misaligned(misaligned), .mem_araddr(mem_araddr), .mem_arprot(mem_arprot),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
  );

  always #5 clk = ~clk;

  // Remember whether the DUT saw reset at the last edge so the slave resets too.
  always @(posedge clk) rst_at_edge <= !rstn;

  // Contents of the simulated instruction memory.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13579bdf;
  endfunction

  // AXI4-Lite read slave with programmable wait states, driven on negedges.
  initial begin : slave
    int          ar_cnt;
    int          r_cnt;
    logic        r_pend;
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] ar_cap;
    logic [31:0] r_addr;
    ar_cnt = 0; r_cnt = 0; r_pend = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
    ar_cap = 32'h0; r_addr = 32'h0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        ar_cnt = 0; r_cnt = 0; r_pend = 1'b0; ar_hs = 1'b0; r_hs = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0;
      end else begin
        if (r_hs) r_pend = 1'b0;
        if (ar_hs) begin
          r_pend = 1'b1; r_cnt = 0; r_addr = ar_cap;
        end
        if (mem_arvalid) begin
          if (ar_cnt >= ar_delay) mem_arready = 1'b1;
          else begin mem_arready = 1'b0; ar_cnt++; end
        end else begin
          mem_arready = 1'b0; ar_cnt = 0;
        end
        if (r_pend && mem_rready) begin
          if (r_cnt >= r_delay) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fixed_en ? fixed_data : memWord(r_addr);
            mem_rresp  = resp_val;
          end else begin
            mem_rvalid = 1'b0; r_cnt++;
          end
        end else begin
          mem_rvalid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata  = $urandom;
          mem_rresp  = 2'($urandom_range(0, 3));
        end
        ar_hs  = mem_arvalid && mem_arready;
        ar_cap = mem_araddr;
        r_hs   = mem_rvalid && mem_rready;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one fetch; returns latency in cycles, arvalid cycles and address/prot violations.
  task automatic applyStimulus(input logic [31:0] p, input int ad, input int rd,
                               input logic [1:0] rs, output int lat, output int arc,
                               output int ar_bad);
    ar_delay = ad; r_delay = rd; resp_val = rs;
    lat = 0; arc = 0; ar_bad = 0;
    @(negedge clk); enabled = 1'b1; pc = p;
    @(negedge clk); enabled = 1'b0; pc = $urandom; lat = 1;
    while (!completed && lat < 200) begin
      if (mem_arvalid) begin
        arc++;
        if (mem_araddr !== {p[31:2], 2'b00}) ar_bad++;
      end
      if (mem_arprot !== 3'b100) ar_bad++;
      @(negedge clk); lat++;
    end
  endtask

  // Reference model: what a completed fetch must report, from the interface rules.
  task automatic modelFetch(input logic [31:0] p, input int ad, input int rd,
                            input logic [1:0] rs, input logic [31:0] data,
                            output logic [31:0] e_instr, output logic e_fault,
                            output logic e_mis, output int e_lat, output int e_arc);
`ifdef FETCHER_ALIGN_CHECK_EN
    if (p[1:0] != 2'b00) begin
      e_instr = NOP; e_fault = 1'b0; e_mis = 1'b1; e_lat = 1; e_arc = 0;
      return;
    end
`endif
    e_mis   = 1'b0;
    e_fault = (rs != 2'b00);
    e_instr = e_fault ? NOP : data;
    e_lat   = 3 + ad + rd;
    e_arc   = 1 + ad;
  endtask

  task automatic doReset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk);
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_completed"}, 32'(completed), 32'h0);
    checkOutput({tag, "_arvalid"}, 32'(mem_arvalid), 32'h0);
    checkOutput({tag, "_rready"}, 32'(mem_rready), 32'h0);
    checkOutput({tag, "_fault"}, 32'(fetch_fault), 32'h0);
    checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'h0);
    checkOutput({tag, "_araddr"}, mem_araddr, 32'h0);
    checkOutput({tag, "_pc_out"}, pc_out, 32'h0);
    checkOutput({tag, "_instr"}, instr_raw, NOP);
  endtask

  // Run one fetch end to end and compare every reported field.
  task automatic fetchAndCheck(input string tag, input logic [31:0] p, input int ad,
                               input int rd, input logic [1:0] rs, input logic [31:0] data);
    int lat, arc, ar_bad, e_lat, e_arc;
    logic [31:0] e_instr;
    logic e_fault, e_mis;
    modelFetch(p, ad, rd, rs, data, e_instr, e_fault, e_mis, e_lat, e_arc);
    applyStimulus(p, ad, rd, rs, lat, arc, ar_bad);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(e_lat));
    checkOutput({tag, "_arvalid_cycles"}, 32'(arc), 32'(e_arc));
    checkOutput({tag, "_ar_stable"}, 32'(ar_bad), 32'h0);
    checkOutput({tag, "_instr"}, instr_raw, e_instr);
    checkOutput({tag, "_pc_out"}, pc_out, p);
    checkOutput({tag, "_fault"}, 32'(fetch_fault), 32'(e_fault));
    checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'(e_mis));
    @(negedge clk);
    checkOutput({tag, "_pulse_clear"}, 32'(completed), 32'h0);
    checkOutput({tag, "_instr_hold"}, instr_raw, e_instr);
  endtask

  typedef struct {
    string       name;
    logic [31:0] pc;
    int          ad;
    int          rd;
    logic [1:0]  rs;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int comps;
    int last_t;
    int gap_bad;
    int guard;
    logic [31:0] hp[4];

    rstn = 1'b0; enabled = 1'b0; pc = 32'h0;
    vecs[0] = '{"zero_wait",  32'h00000100, 0, 0, 2'b00, 32'h00a00093};
    vecs[1] = '{"wait_state", 32'h00000140, 4, 2, 2'b00, 32'h12345678};
    vecs[2] = '{"slverr",     32'h00000180, 0, 0, 2'b10, 32'hdeadbeef};
    vecs[3] = '{"misalign",   32'h00000102, 0, 0, 2'b00, 32'h00000297};
    vecs[4] = '{"decerr",     32'h000001c0, 1, 1, 2'b11, 32'hcafef00d};

    doReset();
    checkReset("reset");

    // Directed vectors with fixed read data.
    fixed_en = 1'b1;
    foreach (vecs[i]) begin
      fixed_data = vecs[i].data;
      fetchAndCheck(vecs[i].name, vecs[i].pc, vecs[i].ad, vecs[i].rd, vecs[i].rs, vecs[i].data);
    end
    fixed_en = 1'b0;

    // Reset while waiting for read data abandons the fetch.
    ar_delay = 0; r_delay = 5; resp_val = 2'b00;
    @(negedge clk); enabled = 1'b1; pc = 32'h600;
    @(negedge clk); enabled = 1'b0;
    guard = 0;
    while (!mem_rready && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("rst_reach_data", 32'(mem_rready), 32'h1);
    rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    checkReset("midrst");
    fetchAndCheck("after_rst", 32'h200, 0, 0, 2'b00, memWord(32'h200));

    // enabled pulses while busy are ignored.
    ar_delay = 2; r_delay = 2; resp_val = 2'b00;
    @(negedge clk); enabled = 1'b1; pc = 32'h400;
    @(negedge clk); enabled = 1'b0;
    comps = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2 || c == 5) begin enabled = 1'b1; pc = 32'h800; end
      else enabled = 1'b0;
      @(negedge clk);
      if (completed) begin
        comps++;
        checkOutput("busy_pc_out", pc_out, 32'h400);
      end
    end
    checkOutput("busy_completions", 32'(comps), 32'h1);

    // Held enabled: back-to-back fetches every 3 cycles.
    ar_delay = 0; r_delay = 0; resp_val = 2'b00;
    hp[0] = 32'h300; hp[1] = 32'h304; hp[2] = 32'h308; hp[3] = 32'h31c;
    @(negedge clk); enabled = 1'b1; pc = hp[0];
    comps = 0; last_t = 0; gap_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (completed) begin
        if (comps < 4) begin
          checkOutput("held_pc_out", pc_out, hp[comps]);
          checkOutput("held_instr", instr_raw, memWord(hp[comps]));
        end
        if (comps > 0 && (c - last_t) != 3) gap_bad++;
        last_t = c;
        comps++;
        if (comps < 4) pc = hp[comps];
        else enabled = 1'b0;
      end
    end
    checkOutput("held_completions", 32'(comps), 32'h4);
    checkOutput("held_gap", 32'(gap_bad), 32'h0);

    // Randomized fetches with spurious rvalid outside the data phase.
    spurious = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [31:0] p;
      logic [1:0]  rs;
      int ad, rd;
      p  = $urandom & 32'h0000ffff;
      if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
      ad = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetchAndCheck("rand", p, ad, rd, rs, memWord({p[31:2], 2'b00}));
    end
    spurious = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
